// File: rtl/dw_pipe_skid_reg.sv
// Credit-based elastic wrapper: fixed-latency never-stalling delay line feeding an output skid FIFO.
// Optional synchronous flush port enabled by defining DW_PIPE_SKID_FLUSH_EN.
module dw_pipe_skid_reg #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef DW_PIPE_SKID_FLUSH_EN
  input  logic             flush,
`endif
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] fill_level
);

  localparam int unsigned      PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  logic             flush_c;
  logic             accept_c;
  logic             pop_c;
  logic             wr_en_c;

  logic [DEPTH-1:0] pv_q, pv_d;
  logic [WIDTH-1:0] pd_q [DEPTH];
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

`ifdef DW_PIPE_SKID_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  assign accept_c = in_valid & in_ready_q;
  assign pop_c    = out_valid_q & out_ready;
  assign wr_en_c  = pv_q[DEPTH-1];

  // Outstanding credits cover pipe + FIFO, so a granted accept always has a FIFO slot on landing.
  always_comb begin
    pv_d     = '0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pv_d[0]  = accept_c;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      pv_d[i] = pv_q[i-1];
    end
    if (wr_en_c) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    fill_d  = fill_q + CNT_W'(wr_en_c) - CNT_W'(pop_c);
    outst_d = outst_q + CNT_W'(accept_c) - CNT_W'(pop_c);
    if (flush_c) begin
      pv_d     = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      outst_d  = '0;
    end
    in_ready_d  = (outst_d < FULL_CNT);
    out_valid_d = (fill_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      outst_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      pv_q        <= pv_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      outst_q     <= outst_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Data path carries no reset; validity is tracked separately in pv_q and the pointers.
  always_ff @(posedge clk) begin
    pd_q[0] <= in_data;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      pd_q[i] <= pd_q[i-1];
    end
    if (wr_en_c) begin
      mem_q[wr_ptr_q] <= pd_q[DEPTH-1];
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = mem_q[rd_ptr_q];
  assign fill_level = fill_q;

endmodule

// File: tb/tb_dw_pipe_skid_reg.sv
// Bench for dw_pipe_skid_reg: two configurations checked against a timestamped queue model.
module tb_dw_pipe_skid_reg;

  logic       clk = 1'b0;
  logic       rst_n;
`ifdef DW_PIPE_SKID_FLUSH_EN
  logic       flush;
`endif

  logic [7:0] in_data_a, out_data_a;
  logic       in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [2:0] fill_a;
  logic [7:0] in_data_b, out_data_b;
  logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [2:0] fill_b;

  always #5 clk = ~clk;

  dw_pipe_skid_reg #(.WIDTH(8), .DEPTH(4), .FIFO_DEPTH(6)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef DW_PIPE_SKID_FLUSH_EN
    .flush      (flush),
`endif
    .in_data    (in_data_a),
    .in_valid   (in_valid_a),
    .in_ready   (in_ready_a),
    .out_data   (out_data_a),
    .out_valid  (out_valid_a),
    .out_ready  (out_ready_a),
    .fill_level (fill_a)
  );

  dw_pipe_skid_reg #(.WIDTH(8), .DEPTH(1), .FIFO_DEPTH(3)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef DW_PIPE_SKID_FLUSH_EN
    .flush      (flush),
`endif
    .in_data    (in_data_b),
    .in_valid   (in_valid_b),
    .in_ready   (in_ready_b),
    .out_data   (out_data_b),
    .out_valid  (out_valid_b),
    .out_ready  (out_ready_b),
    .fill_level (fill_b)
  );

  int         passed, total, fails;
  bit         sel;
  int         m_depth, m_fd, edge_n;
  logic [7:0] q_d[$];
  int         q_t[$];
  logic [7:0] popped_q[$];
  int         acc_obs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic o_ir();
    return sel ? in_ready_b : in_ready_a;
  endfunction
  function automatic logic o_ov();
    return sel ? out_valid_b : out_valid_a;
  endfunction
  function automatic logic [7:0] o_od();
    return sel ? out_data_b : out_data_a;
  endfunction
  function automatic logic [2:0] o_fl();
    return sel ? fill_b : fill_a;
  endfunction

  // Words visible in the FIFO are those whose landing edge has passed.
  function automatic int m_fill();
    int n = 0;
    foreach (q_t[i]) if (q_t[i] <= edge_n) n++;
    return n;
  endfunction

  task automatic drive(input logic vld, input logic [7:0] dat, input logic rdy);
    if (sel) begin
      in_valid_b = vld; in_data_b = dat; out_ready_b = rdy;
    end else begin
      in_valid_a = vld; in_data_a = dat; out_ready_a = rdy;
    end
  endtask

  task automatic cycle(input logic vld, input logic [7:0] dat, input logic rdy);
    logic acc, pop;
    int   fill;
    fill = m_fill();
    acc  = vld && (q_d.size() < m_fd);
    pop  = rdy && (fill > 0);
    drive(vld, dat, rdy);
    if (vld && o_ir()) acc_obs++;
    if (rdy && o_ov()) popped_q.push_back(o_od());
    @(posedge clk);
    edge_n++;
    if (pop) begin
      void'(q_d.pop_front());
      void'(q_t.pop_front());
    end
    if (acc) begin
      q_d.push_back(dat);
      q_t.push_back(edge_n + m_depth);
    end
    #1;
    fill = m_fill();
    chk("in_ready", 32'(o_ir()), 32'(q_d.size() < m_fd));
    chk("out_valid", 32'(o_ov()), 32'(fill > 0));
    chk("fill_level", 32'(o_fl()), 32'(fill));
    if (fill > 0) chk("out_data", 32'(o_od()), 32'(q_d[0]));
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(o_ov()), 32'd0);
    chk("rst_in_ready", 32'(o_ir()), 32'd1);
    chk("rst_fill", 32'(o_fl()), 32'd0);
    q_d.delete();
    q_t.delete();
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic lat_check(input string pfx, input logic [7:0] word);
    cycle(1'b1, word, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      if (i < 4) begin
        chk({pfx, "_early"}, 32'(o_ov()), 32'd0);
      end else if (i == 4) begin
        chk({pfx, "_valid"}, 32'(o_ov()), 32'd1);
        chk({pfx, "_data"}, 32'(o_od()), 32'(word));
      end else begin
        chk({pfx, "_gone"}, 32'(o_ov()), 32'd0);
        chk({pfx, "_fill0"}, 32'(o_fl()), 32'd0);
      end
    end
  endtask

`ifdef DW_PIPE_SKID_FLUSH_EN
  task automatic flush_cycle();
    drive(1'b1, 8'hEE, 1'b1);
    flush = 1'b1;
    @(posedge clk);
    edge_n++;
    q_d.delete();
    q_t.delete();
    #1;
    flush = 1'b0;
    chk("flush_in_ready", 32'(o_ir()), 32'd1);
    chk("flush_out_valid", 32'(o_ov()), 32'd0);
    chk("flush_fill", 32'(o_fl()), 32'd0);
  endtask
`endif

  initial begin
    int bad, ir_low, over;
    passed = 0; total = 0; fails = 0;
    sel = 1'b0; m_depth = 4; m_fd = 6; edge_n = 0; acc_obs = 0;
    rst_n = 1'b1;
`ifdef DW_PIPE_SKID_FLUSH_EN
    flush = 1'b0;
`endif
    in_data_a = '0; in_valid_a = 1'b0; out_ready_a = 1'b0;
    in_data_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b0;
    do_reset();

    // Single word latency.
    lat_check("lat", 8'hA5);

    // Full-rate streaming.
    popped_q.delete();
    ir_low = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, 8'(i), 1'b1);
      if (!o_ir()) ir_low++;
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("stream_cnt", 32'(popped_q.size()), 32'd200);
    bad = 0;
    foreach (popped_q[i]) if (popped_q[i] !== 8'(i)) bad++;
    chk("stream_order", 32'(bad), 32'd0);
    chk("stream_ir_low", 32'(ir_low), 32'd0);

    // Back-pressure fill then drain.
    acc_obs = 0;
    for (int i = 0; i < 12; i++) cycle(1'b1, 8'(8'h10 + acc_obs), 1'b0);
    chk("bp_accepts", 32'(acc_obs), 32'd6);
    chk("bp_ir_low", 32'(o_ir()), 32'd0);
    chk("bp_fill", 32'(o_fl()), 32'd6);
    popped_q.delete();
    cycle(1'b0, 8'h00, 1'b1);
    chk("bp_ir_rise", 32'(o_ir()), 32'd1);
    for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("bp_drain_cnt", 32'(popped_q.size()), 32'd6);
    bad = 0;
    foreach (popped_q[i]) if (popped_q[i] !== 8'(8'h10 + i)) bad++;
    chk("bp_drain_order", 32'(bad), 32'd0);

    // Reset in the middle of back-pressured traffic.
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0);
    do_reset();
    lat_check("post_rst", 8'h3C);

`ifdef DW_PIPE_SKID_FLUSH_EN
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
    flush_cycle();
    lat_check("post_flush", 8'h3C);
`endif

    // Random stalls on the shallow configuration.
    sel = 1'b1; m_depth = 1; m_fd = 3;
    do_reset();
    acc_obs = 0;
    popped_q.delete();
    over = 0;
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      if (o_fl() > 3'd3) over++;
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("rand_fill_max", 32'(over), 32'd0);
    chk("rand_conserve", 32'(popped_q.size()), 32'(acc_obs));
    chk("rand_empty", 32'(o_ov()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
